// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// Package: vga_timing_pkg
// Purpose: shared constants and types for the VGA raster timing generator.
//          Holds the default counter width, the standard 640x480@60 mode
//          constants, and an H/V timing-set record for describing more modes.
// Ports:   none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   // Default counter/coordinate width. 11 bits reaches 2047, enough for any
   // total up to 2048 pixels or lines.
   localparam int VGA_CW = 11;

   // Standard 640x480@60 Hz (25.175 MHz pixel clock) timing.
   localparam int VGA640_H_ACT  = 640;
   localparam int VGA640_H_FP   = 16;
   localparam int VGA640_H_SYNC = 96;
   localparam int VGA640_H_BP   = 48;
   localparam int VGA640_V_ACT  = 480;
   localparam int VGA640_V_FP   = 10;
   localparam int VGA640_V_SYNC = 2;
   localparam int VGA640_V_BP   = 33;
   localparam bit VGA640_H_POL  = 1'b0;
   localparam bit VGA640_V_POL  = 1'b0;

   // Longest supported sync/active re-alignment delay, in pixels.
   localparam int VGA_MAX_SYNC_DELAY = 7;

   // One axis of a timing set: active, front porch, sync and back porch.
   typedef struct packed {
      logic [15:0] act;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } vga_axis_t;

   // Complete mode description: both axes plus sync polarities.
   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
      logic      h_pol;
      logic      v_pol;
   } vga_mode_t;

   localparam vga_mode_t VGA_MODE_640X480_60 = '{
      h:     '{act: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
      v:     '{act: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33},
      h_pol: 1'b0,
      v_pol: 1'b0
   };

   // Total period of one axis (pixels per line or lines per frame).
   function automatic int axis_total(input vga_axis_t a);
      return int'(a.act) + int'(a.fp) + int'(a.sync) + int'(a.bp);
   endfunction

   // Smallest counter width able to hold total-1.
   function automatic int axis_width(input int total);
      int w;
      w = 1;
      while ((total - 1) >= (1 << w)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// -----------------------------------------------------------------------------
// Module: vga_sync_delay
// Purpose: N-deep, ce-gated shift register with a per-bit reset value. Used to
//          line the sync/active flags up with downstream pixel-fetch latency.
//          N=0 makes it a plain wire-through.
// Ports:
//   clk  in   1   pixel/system clock
//   rst  in   1   asynchronous reset, active-low
//   ce   in   1   pixel strobe; the pipe shifts only when ce=1
//   d    in   W   data into the pipe
//   q    out  W   data N ce-strobes later (d itself when N=0)
// -----------------------------------------------------------------------------
module vga_sync_delay
   import vga_timing_pkg::*;
#(
   parameter int           W       = 1,
   parameter int           N       = 0,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // At least one stage is always declared so the array is never empty; for
   // N=0 the output mux bypasses it and synthesis drops the unused flops.
   localparam int DEPTH = (N > 0) ? N : 1;

   if (N < 0 || N > VGA_MAX_SYNC_DELAY) begin : g_bad_depth
      $error("vga_sync_delay: N out of range");
   end

   logic [W-1:0] pipe [DEPTH];

   // Every stage resets to RST_VAL so the delayed outputs show the idle
   // level straight out of reset instead of a spurious pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe[i] <= RST_VAL;
         end
      end else if (ce) begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign q = (N == 0) ? d : pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// Module: vga_timing_gen
// Purpose: parametrised VGA raster timing generator. Two free-running counters
//          (stage 0) walk the raster; stage 1 registers the coordinates and
//          flags derived from them. hsync/vsync/active may be delayed a further
//          SYNC_DELAY pixels to match downstream pixel-fetch latency.
// Ports:
//   clk          in   1   pixel/system clock
//   rst          in   1   asynchronous reset, active-low
//   ce           in   1   pixel strobe; all state advances only when ce=1
//   hsync        out  1   horizontal sync, asserted level H_POL
//   vsync        out  1   vertical sync, asserted level V_POL
//   x            out  CW  current pixel column, 0..H_TOTAL-1
//   y            out  CW  current line, 0..V_TOTAL-1
//   active       out  1   1 when x<H_ACT and y<V_ACT
//   line_start   out  1   1 for one pixel period when x==0
//   frame_start  out  1   1 for one pixel period when x==0 and y==0
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CW         = VGA_CW,
   parameter int H_ACT      = VGA640_H_ACT,
   parameter int H_FP       = VGA640_H_FP,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BP       = VGA640_H_BP,
   parameter int V_ACT      = VGA640_V_ACT,
   parameter int V_FP       = VGA640_V_FP,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BP       = VGA640_V_BP,
   parameter bit H_POL      = VGA640_H_POL,
   parameter bit V_POL      = VGA640_V_POL,
   parameter int SYNC_DELAY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          active,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

   // Parameter sanity is an elaboration-time matter only.
   if (CW < 1 || CW > 30 ||
       H_ACT < 1 || H_FP < 0 || H_SYNC < 1 || H_BP < 0 ||
       V_ACT < 1 || V_FP < 0 || V_SYNC < 1 || V_BP < 0 ||
       (H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW) ||
       SYNC_DELAY < 0 || SYNC_DELAY > VGA_MAX_SYNC_DELAY) begin : g_bad_cfg
      $error("vga_timing_gen: invalid timing parameters");
   end

   // Raster landmarks at counter width; all comparisons are unsigned.
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_CW = CW'(H_ACT);
   localparam logic [CW-1:0] V_ACT_CW = CW'(V_ACT);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACT + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACT + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACT + V_FP + V_SYNC - 1);

   // ---------------------------------------------------------------------
   // Stage 0: raster counters
   // ---------------------------------------------------------------------
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (ce) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 0 decode
   // ---------------------------------------------------------------------
   logic hs_win;
   logic vs_win;
   logic act_win;

   assign hs_win  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
   assign vs_win  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
   assign act_win = (h_cnt < H_ACT_CW) && (v_cnt < V_ACT_CW);

   // ---------------------------------------------------------------------
   // Stage 1: registered coordinates and flags, all aligned to x/y
   // ---------------------------------------------------------------------
   logic hsync_s1;
   logic vsync_s1;
   logic active_s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hsync_s1    <= ~H_POL;
         vsync_s1    <= ~V_POL;
         active_s1   <= 1'b0;
      end else if (ce) begin
         x           <= h_cnt;
         y           <= v_cnt;
         line_start  <= (h_cnt == '0);
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         // vsync follows v_cnt, which only moves on the h wrap, so it spans
         // whole lines starting at x=0.
         hsync_s1    <= hs_win ? H_POL : ~H_POL;
         vsync_s1    <= vs_win ? V_POL : ~V_POL;
         active_s1   <= act_win;
      end
   end

   // ---------------------------------------------------------------------
   // Optional re-alignment of {hsync,vsync,active}; x/y stay undelayed
   // ---------------------------------------------------------------------
   localparam logic [2:0] FLAG_IDLE = {~H_POL, ~V_POL, 1'b0};

   vga_sync_delay #(
      .W       (3),
      .N       (SYNC_DELAY),
      .RST_VAL (FLAG_IDLE)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   ({hsync_s1, vsync_s1, active_s1}),
      .q   ({hsync, vsync, active})
   );

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// Testbench: tb_vga_timing_gen
// Reduced mode H=8/2/3/3 (16 pixels), V=4/1/2/1 (8 lines). Three generators
// share clk/rst/ce: u_a (active-low syncs, no delay), u_b (active-high syncs),
// u_c (active-low syncs, SYNC_DELAY=2). Expected output words come from a
// raster model indexed by the number of ce strobes since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int CW = 11;
   localparam int SW = 5 + 2 * CW;   // {hsync,vsync,active,line_start,frame_start,x,y}

   logic clk;
   logic rst_n;
   logic ce;

   logic          hs_a, vs_a, ac_a, ls_a, fs_a;
   logic [CW-1:0] x_a, y_a;
   logic          hs_b, vs_b, ac_b, ls_b, fs_b;
   logic [CW-1:0] x_b, y_b;
   logic          hs_c, vs_c, ac_c, ls_c, fs_c;
   logic [CW-1:0] x_c, y_c;

   int checks;
   int errors;
   int n_ce;   // ce strobes accepted since reset release

   logic [SW-1:0] exp_qa[$];
   logic [SW-1:0] exp_qb[$];
   logic [SW-1:0] exp_qc[$];

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------
   vga_timing_gen #(.CW(CW), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(0)) u_a (
      .clk(clk), .rst(rst_n), .ce(ce), .hsync(hs_a), .vsync(vs_a), .x(x_a), .y(y_a),
      .active(ac_a), .line_start(ls_a), .frame_start(fs_a));

   vga_timing_gen #(.CW(CW), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .H_POL(1'b1), .V_POL(1'b1), .SYNC_DELAY(0)) u_b (
      .clk(clk), .rst(rst_n), .ce(ce), .hsync(hs_b), .vsync(vs_b), .x(x_b), .y(y_b),
      .active(ac_b), .line_start(ls_b), .frame_start(fs_b));

   vga_timing_gen #(.CW(CW), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(2)) u_c (
      .clk(clk), .rst(rst_n), .ce(ce), .hsync(hs_c), .vsync(vs_c), .x(x_c), .y(y_c),
      .active(ac_c), .line_start(ls_c), .frame_start(fs_c));

   // ---------------------------------------------------------------------
   // Raster model: n strobes after reset the outputs show raster position
   // n-1 (frame of 128 pixels); delayed flags show position n-1-dly.
   // ---------------------------------------------------------------------
   function automatic logic [SW-1:0] model(input int n, input bit hp, input bit vp,
                                           input int dly);
      int pos, pd, hx, hy;
      logic hs, vs, ac, ls, fs;
      logic [CW-1:0] ex, ey;
      hs = ~hp; vs = ~vp; ac = 1'b0; ls = 1'b0; fs = 1'b0;
      ex = '0;  ey = '0;
      if (n >= 1) begin
         pos = (n - 1) % 128;
         ex  = CW'(pos % 16);
         ey  = CW'(pos / 16);
         ls  = (pos % 16 == 0);
         fs  = (pos == 0);
      end
      if (n - 1 - dly >= 0) begin
         pd = (n - 1 - dly) % 128;
         hx = pd % 16;
         hy = pd / 16;
         hs = (hx >= 10 && hx <= 12) ? hp : ~hp;
         vs = (hy >= 5 && hy <= 6) ? vp : ~vp;
         ac = (hx < 8) && (hy < 4);
      end
      return {hs, vs, ac, ls, fs, ex, ey};
   endfunction

   // ---------------------------------------------------------------------
   // Driver: one clock. Starts and ends at a falling edge.
   // ---------------------------------------------------------------------
   task automatic cycle(input bit ce_v);
      logic [SW-1:0] ea, eb, ec;
      ce = ce_v;
      if (rst_n && ce_v) n_ce++;
      exp_qa.push_back(model(n_ce, 1'b0, 1'b0, 0));
      exp_qb.push_back(model(n_ce, 1'b1, 1'b1, 0));
      exp_qc.push_back(model(n_ce, 1'b0, 1'b0, 2));
      @(posedge clk);
      #1;
      ea = exp_qa.pop_front();
      eb = exp_qb.pop_front();
      ec = exp_qc.pop_front();
      checks += 3;
      if ({hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a} !== ea) begin
         errors++;
         $display("FAIL sb_a n=%0d got %h exp %h", n_ce,
                  {hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a}, ea);
      end
      if ({hs_b, vs_b, ac_b, ls_b, fs_b, x_b, y_b} !== eb) begin
         errors++;
         $display("FAIL sb_b n=%0d got %h exp %h", n_ce,
                  {hs_b, vs_b, ac_b, ls_b, fs_b, x_b, y_b}, eb);
      end
      if ({hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c} !== ec) begin
         errors++;
         $display("FAIL sb_c n=%0d got %h exp %h", n_ce,
                  {hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c}, ec);
      end
      @(negedge clk);
   endtask

   // Synchronous-looking reset pulse: low across one rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      n_ce  = 0;
      @(posedge clk);
      #1;
      checks += 2;
      if ({hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a} !== model(0, 1'b0, 1'b0, 0)) begin
         errors++;
         $display("FAIL reset_a got %h", {hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a});
      end
      if ({hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c} !== model(0, 1'b0, 1'b0, 2)) begin
         errors++;
         $display("FAIL reset_c got %h", {hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      ce = 1'b1;
      do_reset();
      // Active-high syncs idle low in reset.
      rst_n = 1'b0;
      #1;
      checks++;
      if (hs_b !== 1'b0 || vs_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_pol got hs=%b vs=%b exp 0 0", hs_b, vs_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_ce = 0;
      cycle(1'b1);
      checks++;
      if (x_a !== 0 || y_a !== 0 || fs_a !== 1'b1) begin
         errors++;
         $display("FAIL first_ce got x=%0d y=%0d fs=%b exp 0 0 1", x_a, y_a, fs_a);
      end
   endtask

   task automatic test_raster();
      int n_fs, n_hs, n_vs, n_ac, n_ls;
      do_reset();
      n_fs = 0; n_hs = 0; n_vs = 0; n_ac = 0; n_ls = 0;
      for (int i = 0; i < 128; i++) begin
         cycle(1'b1);
         n_fs += int'(fs_a);
         n_ls += int'(ls_a);
         n_hs += int'(hs_a == 1'b0);
         n_vs += int'(vs_a == 1'b0);
         n_ac += int'(ac_a);
      end
      checks += 5;
      if (n_fs != 1)  begin errors++; $display("FAIL frame_start_cnt got %0d exp 1", n_fs); end
      if (n_ls != 8)  begin errors++; $display("FAIL line_start_cnt got %0d exp 8", n_ls); end
      if (n_hs != 24) begin errors++; $display("FAIL hsync_low_cnt got %0d exp 24", n_hs); end
      if (n_vs != 32) begin errors++; $display("FAIL vsync_low_cnt got %0d exp 32", n_vs); end
      if (n_ac != 32) begin errors++; $display("FAIL active_cnt got %0d exp 32", n_ac); end
   endtask

   task automatic test_polarity();
      int n_hs, n_vs;
      n_hs = 0; n_vs = 0;
      for (int i = 0; i < 128; i++) begin
         cycle(1'b1);
         n_hs += int'(hs_b == 1'b1);
         n_vs += int'(vs_b == 1'b1);
      end
      checks += 2;
      if (n_hs != 24) begin errors++; $display("FAIL pol_hsync_cnt got %0d exp 24", n_hs); end
      if (n_vs != 32) begin errors++; $display("FAIL pol_vsync_cnt got %0d exp 32", n_vs); end
   endtask

   task automatic test_ce_div();
      int run_x, run_fs, n_runs;
      logic [CW-1:0] prev_x;
      bit first;
      do_reset();
      run_x = 0; run_fs = 0; n_runs = 0; first = 1'b1; prev_x = x_a;
      for (int k = 0; k < 60; k++) begin
         cycle(k % 3 == 0);
         run_fs += int'(fs_a);
         if (x_a != prev_x) begin
            if (!first) begin
               checks++;
               n_runs++;
               if (run_x != 3) begin
                  errors++;
                  $display("FAIL ce_x_run x=%0d got %0d exp 3", prev_x, run_x);
               end
            end
            first  = 1'b0;
            run_x  = 1;
            prev_x = x_a;
         end else begin
            run_x++;
         end
      end
      checks += 2;
      if (run_fs != 3) begin errors++; $display("FAIL ce_fs_len got %0d exp 3", run_fs); end
      if (n_runs < 10) begin errors++; $display("FAIL ce_run_count got %0d exp >=10", n_runs); end
   endtask

   task automatic test_delay();
      int i_x, i_h, x_fall;
      logic prev_ac;
      do_reset();
      i_x = -1; i_h = -1; x_fall = -1; prev_ac = ac_c;
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1);
         if (i_x < 0 && x_c == 10) i_x = i;
         if (i_h < 0 && hs_c == 1'b0) i_h = i;
         if (x_fall < 0 && prev_ac && !ac_c) x_fall = int'(x_c);
         prev_ac = ac_c;
      end
      checks += 2;
      if (i_x < 0 || i_h - i_x != 2) begin
         errors++;
         $display("FAIL delay_hsync got lag %0d exp 2", i_h - i_x);
      end
      if (x_fall != 10) begin
         errors++;
         $display("FAIL delay_active_fall got x=%0d exp 10", x_fall);
      end
   endtask

   task automatic test_async_reset();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle(1'b1);
         if (x_a == 6 && y_a == 2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL async_reach got x=%0d y=%0d exp 6 2", x_a, y_a);
      end
      // Assert reset between edges and look before any rising edge.
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      checks += 3;
      if ({hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a} !== model(0, 1'b0, 1'b0, 0)) begin
         errors++;
         $display("FAIL async_a got %h", {hs_a, vs_a, ac_a, ls_a, fs_a, x_a, y_a});
      end
      if ({hs_b, vs_b, ac_b, ls_b, fs_b, x_b, y_b} !== model(0, 1'b1, 1'b1, 0)) begin
         errors++;
         $display("FAIL async_b got %h", {hs_b, vs_b, ac_b, ls_b, fs_b, x_b, y_b});
      end
      if ({hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c} !== model(0, 1'b0, 1'b0, 2)) begin
         errors++;
         $display("FAIL async_c got %h", {hs_c, vs_c, ac_c, ls_c, fs_c, x_c, y_c});
      end
      n_ce = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1);
      checks++;
      if (x_a !== 0 || y_a !== 0 || fs_a !== 1'b1) begin
         errors++;
         $display("FAIL async_restart got x=%0d y=%0d fs=%b exp 0 0 1", x_a, y_a, fs_a);
      end
      // Random pixel strobes afterwards.
      for (int i = 0; i < 80; i++) begin
         cycle(1'($urandom_range(0, 1)));
      end
   endtask

   // ---------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------
   initial begin
      checks = 0;
      errors = 0;
      n_ce   = 0;
      rst_n  = 1'b0;
      ce     = 1'b0;
      @(negedge clk);
      test_reset();
      test_raster();
      test_polarity();
      test_ce_div();
      test_delay();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
